// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution unit: ARM condition codes and the NZCV flag word.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // Bit positions inside the two-bit FlagW request.
    localparam int FLAG_NZ = 1;
    localparam int FLAG_CV = 0;

endpackage

// File: rtl/cond_unit_mc_if.sv
// Decoder/FSM-facing bundle of the conditional-execution unit; master = controller, slave = unit.
interface cond_unit_mc_if #(parameter int NUM_CTX = 2);

    localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

    logic             InstrStart;
    logic [CTX_W-1:0] CtxSel;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NextPC;
    logic             FlagSave;
    logic             FlagRestore;
    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondExR;
    logic [3:0]       Flags;
    logic             CondUndef;

    modport master (
        output InstrStart, CtxSel, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NextPC,
               FlagSave, FlagRestore,
        input  PCWrite, RegWrite, MemWrite, CondExR, Flags, CondUndef
    );

    modport slave (
        input  InstrStart, CtxSel, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NextPC,
               FlagSave, FlagRestore,
        output PCWrite, RegWrite, MemWrite, CondExR, Flags, CondUndef
    );

endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator; NV never executes and is flagged as undefined.
module cond_eval
    import cond_pkg::*;
(
    input  cond_e cond,
    input  nzcv_t flags,
    output logic  cond_ex,
    output logic  undef
);

    // Standard ARM condition table.
    always_comb begin
        cond_ex = 1'b0;
        undef   = 1'b0;
        case (cond)
            EQ: cond_ex = flags.z;
            NE: cond_ex = ~flags.z;
            CS: cond_ex = flags.c;
            CC: cond_ex = ~flags.c;
            MI: cond_ex = flags.n;
            PL: cond_ex = ~flags.n;
            VS: cond_ex = flags.v;
            VC: cond_ex = ~flags.v;
            HI: cond_ex = flags.c & ~flags.z;
            LS: cond_ex = ~flags.c | flags.z;
            GE: cond_ex = (flags.n == flags.v);
            LT: cond_ex = (flags.n != flags.v);
            GT: cond_ex = ~flags.z & (flags.n == flags.v);
            LE: cond_ex = flags.z | (flags.n != flags.v);
            AL: cond_ex = 1'b1;
            NV: begin
                cond_ex = 1'b0;
                undef   = 1'b1;
            end
            default: begin
                cond_ex = 1'b0;
                undef   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cond_unit_mc.sv
// Multi-context conditional-execution unit: per-context NZCV banks, latched CondEx, write gating.
// Optional shadow save/restore per context is built when COND_FLAG_SAVE_EN is defined.
module cond_unit_mc
    import cond_pkg::*;
#(
    parameter int NUM_CTX = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    cond_unit_mc_if.slave        bus
);

    localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

    nzcv_t [NUM_CTX-1:0] flags_q, flags_d;
    logic                cx_q, cx_d;
    logic [CTX_W-1:0]    ctx_q, ctx_d;
    logic                undef_q, undef_d;

    nzcv_t               sel_flags_s;
    logic                cond_ex_s;
    logic                undef_s;
    logic                cond_eff_s;
    logic [CTX_W-1:0]    wr_ctx_s;

    cond_eval u_eval (
        .cond    (cond_e'(bus.Cond)),
        .flags   (sel_flags_s),
        .cond_ex (cond_ex_s),
        .undef   (undef_s)
    );

    // Readout of bank CtxSel; an index with no bank behind it reads as zero.
    always_comb begin
        sel_flags_s = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            sel_flags_s = (bus.CtxSel == CTX_W'(i)) ? flags_q[i] : sel_flags_s;
        end
    end

    assign cond_eff_s = bus.InstrStart ? cond_ex_s : cx_q;
    assign wr_ctx_s   = bus.InstrStart ? bus.CtxSel : ctx_q;

`ifdef COND_FLAG_SAVE_EN
    nzcv_t [NUM_CTX-1:0] shadow_q, shadow_d;

    // Shadow bank registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    logic unused_save_s;
    assign unused_save_s = bus.FlagSave ^ bus.FlagRestore;
`endif

    // Next-state: gated ALU flag writes, then save/restore (restore overrides the ALU write).
    always_comb begin
        flags_d = flags_q;
        for (int i = 0; i < NUM_CTX; i++) begin
            if ((wr_ctx_s == CTX_W'(i)) && cond_eff_s) begin
                if (bus.FlagW[FLAG_NZ]) begin
                    flags_d[i].n = bus.ALUFlags[3];
                    flags_d[i].z = bus.ALUFlags[2];
                end else begin
                    flags_d[i].n = flags_q[i].n;
                    flags_d[i].z = flags_q[i].z;
                end
                if (bus.FlagW[FLAG_CV]) begin
                    flags_d[i].c = bus.ALUFlags[1];
                    flags_d[i].v = bus.ALUFlags[0];
                end else begin
                    flags_d[i].c = flags_q[i].c;
                    flags_d[i].v = flags_q[i].v;
                end
            end else begin
                flags_d[i] = flags_q[i];
            end
        end
`ifdef COND_FLAG_SAVE_EN
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (bus.CtxSel == CTX_W'(i)) begin
                if (bus.FlagRestore) begin
                    flags_d[i] = shadow_q[i];
                end else if (bus.FlagSave) begin
                    shadow_d[i] = flags_q[i];
                end else begin
                    shadow_d[i] = shadow_q[i];
                end
            end else begin
                shadow_d[i] = shadow_q[i];
            end
        end
`endif
        cx_d    = bus.InstrStart ? cond_ex_s : cx_q;
        ctx_d   = bus.InstrStart ? bus.CtxSel : ctx_q;
        undef_d = bus.InstrStart & undef_s;
    end

    // Flag banks and per-instruction latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
            cx_q    <= 1'b0;
            ctx_q   <= '0;
            undef_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cx_q    <= cx_d;
            ctx_q   <= ctx_d;
            undef_q <= undef_d;
        end
    end

    // Reset forces the gated enables low immediately, not just via the cleared latch.
    always_comb begin
        bus.RegWrite  = ~reset & bus.RegW & cond_eff_s;
        bus.MemWrite  = ~reset & bus.MemW & cond_eff_s;
        bus.PCWrite   = bus.NextPC | (~reset & bus.PCS & cond_eff_s);
        bus.CondExR   = cx_q;
        bus.Flags     = sel_flags_s;
        bus.CondUndef = undef_q;
    end

endmodule
